// File: rtl/guess_filter.sv
// Key-event filter: debounces held keys into single-cycle guess/start/dup pulses
// and tracks per-round guessed letters. Optional macro: GUESS_FILTER_DUP_REJECT_EN.
module guess_filter #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        key_held_i,
  input  logic [4:0]  letter_i,
  input  logic        round_clear_i,
  output logic        guess_valid_o,
  output logic [4:0]  guess_letter_o,
  output logic        start_pulse_o,
  output logic        dup_pulse_o,
  output logic [25:0] guessed_o,
  output logic [4:0]  guess_count_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, HELD} state_t;

  localparam logic [7:0] CNT_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [4:0] START_KEY = 5'd26;
  localparam logic [4:0] MAX_COUNT = 5'd26;

  state_t      state_q;
  logic [4:0]  cand_q;
  logic [7:0]  cnt_q;
  logic        guess_valid_q, start_pulse_q, dup_pulse_q;
  logic [4:0]  guess_letter_q;
  logic [25:0] guessed_q;
  logic [4:0]  count_q;

  logic        guess_valid_d, start_pulse_d, dup_pulse_d;
  logic [25:0] guessed_d;
  logic [4:0]  count_d;
  logic [31:0] guessed_ext;
  logic        emit, is_letter, was_set, new_bit;

  always_comb begin
    emit        = (state_q == EMIT);
    is_letter   = (cand_q < START_KEY);
    guessed_ext = {6'b0, guessed_q};
    was_set     = guessed_ext[cand_q];
    new_bit     = emit && is_letter && !was_set;
`ifdef GUESS_FILTER_DUP_REJECT_EN
    guess_valid_d = emit && is_letter && !was_set;
    dup_pulse_d   = emit && is_letter && was_set;
`else
    guess_valid_d = emit && is_letter;
    dup_pulse_d   = 1'b0;
`endif
    start_pulse_d = emit && (cand_q == START_KEY);

    guessed_d = guessed_q;
    count_d   = count_q;
    if (new_bit) begin
      guessed_d = guessed_q | (26'(1) << cand_q);
      count_d   = (count_q >= MAX_COUNT) ? MAX_COUNT : count_q + 5'd1;
    end
    // A clear in the EMIT cycle still lets the pulse fire but discards the update
    if (round_clear_i) begin
      guessed_d = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      cand_q         <= '0;
      cnt_q          <= '0;
      guess_valid_q  <= 1'b0;
      start_pulse_q  <= 1'b0;
      dup_pulse_q    <= 1'b0;
      guess_letter_q <= '0;
      guessed_q      <= '0;
      count_q        <= '0;
    end else begin
      guess_valid_q <= guess_valid_d;
      start_pulse_q <= start_pulse_d;
      dup_pulse_q   <= dup_pulse_d;
      guessed_q     <= guessed_d;
      count_q       <= count_d;
      if (emit) guess_letter_q <= cand_q;

      case (state_q)
        IDLE: begin
          if (key_held_i) begin
            state_q <= SETTLE;
            cand_q  <= letter_i;
            cnt_q   <= '0;
          end
        end
        SETTLE: begin
          if (!key_held_i) begin
            state_q <= IDLE;
          end else if (letter_i != cand_q) begin
            cand_q <= letter_i;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= EMIT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        EMIT: state_q <= HELD;
        HELD: begin
          // Held key never re-fires; only a rollover to another key restarts settling
          if (!key_held_i) begin
            state_q <= IDLE;
          end else if (letter_i != cand_q) begin
            state_q <= SETTLE;
            cand_q  <= letter_i;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign guess_valid_o  = guess_valid_q;
  assign start_pulse_o  = start_pulse_q;
  assign dup_pulse_o    = dup_pulse_q;
  assign guess_letter_o = guess_letter_q;
  assign guessed_o      = guessed_q;
  assign guess_count_o  = count_q;

endmodule

// File: tb/tb_guess_filter.sv
// Self-checking bench for guess_filter: directed test-plan sequences plus
// randomized key streams against a run-length reference model.
module tb_guess_filter;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_held;
  logic [4:0]  letter;
  logic        round_clear;
  logic        guess_valid, start_pulse, dup_pulse;
  logic [4:0]  guess_letter;
  logic [25:0] guessed;
  logic [4:0]  guess_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          run;
  int          cur;
  bit          locked, pend;
  logic [25:0] m_guessed;
  int          m_count;
  logic        m_gv, m_st, m_dup;
  logic [4:0]  m_letter;

  guess_filter #(.SETTLE_CYCLES(S)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .key_held_i     (key_held),
    .letter_i       (letter),
    .round_clear_i  (round_clear),
    .guess_valid_o  (guess_valid),
    .guess_letter_o (guess_letter),
    .start_pulse_o  (start_pulse),
    .dup_pulse_o    (dup_pulse),
    .guessed_o      (guessed),
    .guess_count_o  (guess_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Event rule: a letter held and stable for S+1 consecutive samples fires once;
  // the pulse appears one edge later, and the sample on that edge is not looked at.
  task automatic model_edge();
    m_gv = 0; m_st = 0; m_dup = 0;
    if (reset) begin
      run = 0; cur = 0; locked = 0; pend = 0;
      m_guessed = '0; m_count = 0; m_letter = '0;
      return;
    end
    if (pend) begin
      m_letter = 5'(cur);
      if (cur < 26) begin
        bit seen = m_guessed[cur];
`ifdef GUESS_FILTER_DUP_REJECT_EN
        if (seen) m_dup = 1; else m_gv = 1;
`else
        m_gv = 1;
`endif
        if (!seen) begin
          m_guessed[cur] = 1'b1;
          m_count = (m_count < 26) ? m_count + 1 : 26;
        end
      end else if (cur == 26) begin
        m_st = 1;
      end
    end
    if (round_clear) begin
      m_guessed = '0;
      m_count = 0;
    end
    if (pend) begin
      pend = 0;
      locked = 1;
    end else if (!key_held) begin
      run = 0;
      locked = 0;
    end else if (run > 0 && int'(letter) == cur) begin
      if (!locked) begin
        run++;
        if (run == S + 1) pend = 1;
      end
    end else begin
      cur = int'(letter);
      run = 1;
      locked = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("guess_valid", 32'(guess_valid), 32'(m_gv));
    chk("start_pulse", 32'(start_pulse), 32'(m_st));
    chk("dup_pulse", 32'(dup_pulse), 32'(m_dup));
    chk("guess_letter", 32'(guess_letter), 32'(m_letter));
    chk("guessed", 32'(guessed), 32'(m_guessed));
    chk("guess_count", 32'(guess_count), 32'(m_count));
  endtask

  task automatic drive(input logic h, input logic [4:0] l, input logic c, input int n);
    key_held = h; letter = l; round_clear = c;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; key_held = 1'b0; letter = '0; round_clear = 1'b0;
    step(); step();
    chk("reset_guessed", 32'(guessed), 32'h0);
    chk("reset_count", 32'(guess_count), 32'h0);
    reset = 1'b0;
    drive(0, 0, 0, 2);

    // single press of letter 4, held long
    drive(1, 4, 0, 50);
    chk("first_guessed", 32'(guessed), 32'h10);
    chk("first_count", 32'(guess_count), 32'd1);
    drive(0, 4, 0, 4);
    // re-press same letter
    drive(1, 4, 0, 10);
    chk("repress_count", 32'(guess_count), 32'd1);
    drive(0, 4, 0, 3);

    // bouncing 7/8 then settling on 8
    for (int i = 0; i < 5; i++) begin
      drive(1, 7, 0, 2);
      drive(1, 8, 0, 2);
    end
    drive(1, 8, 0, 10);
    chk("bounce_guessed", 32'(guessed), 32'h110);
    drive(0, 0, 0, 3);

    // short press, start key, unmapped key
    drive(1, 12, 0, 3);
    drive(0, 12, 0, 5);
    drive(1, 26, 0, 10);
    drive(0, 26, 0, 3);
    drive(1, 30, 0, 10);
    drive(0, 30, 0, 3);

    // round_clear in the EMIT cycle of letter 2
    drive(1, 2, 0, 5);
    drive(1, 2, 1, 1);
    drive(1, 2, 0, 5);
    chk("clear_guessed", 32'(guessed), 32'h0);
    chk("clear_count", 32'(guess_count), 32'd0);
    drive(0, 2, 0, 3);
    drive(1, 2, 0, 10);
    chk("repress2_count", 32'(guess_count), 32'd1);
    drive(0, 2, 0, 3);

    // randomized key streams
    for (int seg = 0; seg < 700; seg++) begin
      logic        h;
      logic [4:0]  l;
      int          len;
      h   = ($urandom_range(0, 3) != 0);
      l   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      len = $urandom_range(1, 9);
      key_held = h; letter = l;
      for (int i = 0; i < len; i++) begin
        round_clear = ($urandom_range(0, 39) == 0);
        reset       = ($urandom_range(0, 299) == 0);
        step();
      end
      reset = 1'b0;
      round_clear = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_filter.md
# guess_filter

Converts the raw keyboard event stream (key-held level plus decoded 5-bit letter) into clean single-cycle game events: one `guess_valid` pulse per distinct key press, a separate `start_pulse` for the start key, and a `dup_pulse` for letters already tried this round. Sits between the letter decoder and `game_state` / `level_select`. It replaces direct use of the `makeBreak` level, which re-loads on every cycle a key is held. It also keeps the per-round guessed-letter vector and distinct-guess count.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive cycles the letter must be stable while held before an event fires; legal 1..255.
- `clk` in 1: system clock (CLOCK_50).
- `reset` in 1: synchronous, active-high.
- `key_held` in 1: driver `makeBreak` level; 1 while a make has been seen without a matching break.
- `letter` in 5: decoder output; 0–25 = A–Z, 26 = start key, 27–31 = unmapped.
- `round_clear` in 1: one-cycle request to clear guess history (new round).
- `guess_valid` out 1: one-cycle pulse, new letter guess.
- `guess_letter` out 5: letter for the current event; valid while any pulse is high, otherwise holds its last value.
- `start_pulse` out 1: one-cycle pulse, start key.
- `dup_pulse` out 1: one-cycle pulse, letter already guessed this round.
- `guessed` out 26: bit n set once letter n has been accepted this round.
- `guess_count` out 5: number of distinct accepted letters this round, 0–26.

## Operation
- FSM states: IDLE, SETTLE, EMIT, HELD. Internal registers `cand` (5 bits) and `cnt` (8 bits).
- IDLE:
  - `key_held`=1 → SETTLE, `cand`←`letter`, `cnt`←0.
- SETTLE:
  - `key_held`=0 → IDLE, no event.
  - `letter`≠`cand` → `cand`←`letter`, `cnt`←0, stay.
  - Otherwise, `cnt`==SETTLE_CYCLES-1 → EMIT; else `cnt`++.
- EMIT (exactly one cycle, then HELD). Classify `cand`:
  - 0–25 and `guessed[cand]`=0: `guess_valid`=1, set `guessed[cand]`, `guess_count`++.
  - 0–25 and `guessed[cand]`=1: `dup_pulse`=1; vector and count unchanged.
  - 26: `start_pulse`=1.
  - 27–31: no pulse; `guess_letter` still updates.
- HELD:
  - `key_held`=0 → IDLE.
  - `letter`≠`cand` (rollover to another key) → SETTLE, `cand`←`letter`, `cnt`←0.
  - Otherwise stay. A held key never re-fires (typematic repeat suppressed).
- At most one of `guess_valid`/`start_pulse`/`dup_pulse` is high in any cycle.
- `round_clear`:
  - `guessed`←0 and `guess_count`←0 at the next edge, in any state; the FSM is unaffected.
  - Same cycle as EMIT: classification uses the pre-clear vector and the pulse still fires, but clear wins, so the bit is not set and the count stays 0.
- `guess_count` saturates at 26. It cannot legally exceed 26; saturation is a safety net.

## Timing
- Reset: state IDLE, `cnt`=0, `cand`=0, all pulses 0, `guess_letter`=0, `guessed`=0, `guess_count`=0.
- Reset during SETTLE or EMIT aborts the event; no pulse follows.
- Latency: `key_held` first sampled high at edge k with a stable letter → pulse high during cycle k+SETTLE_CYCLES+1 (between that edge and the next).
- `guessed` / `guess_count` update at the edge that ends EMIT.
- A letter change during SETTLE restarts the full SETTLE_CYCLES window.
- Release and re-press of the same key (through IDLE) produces a new event, which is a `dup_pulse` for a letter.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Configuration
- `GUESS_FILTER_DUP_REJECT_EN` defined:
  - Duplicate detection as above.
- `GUESS_FILTER_DUP_REJECT_EN` undefined:
  - Every letter 0–25 event fires `guess_valid`.
  - `dup_pulse` is tied 0.
  - `guessed` bits still set.
  - `guess_count` increments only when the bit was previously clear.

## Test plan
- Reset, then hold `letter`=4 with `key_held`=1 for 50 cycles (SETTLE_CYCLES=4) → exactly one `guess_valid` with `guess_letter`=4, 5 cycles after the first high sample; `guessed`=26'h10, `guess_count`=1.
- Press/release 4, then press 4 again → second press gives `dup_pulse`=1 with `guess_valid`=0; count stays 1. Without the macro → second `guess_valid`, count stays 1.
- `letter` toggles 7↔8 every 2 cycles while held, then settles on 8 → single `guess_valid` for 8 only, 5 cycles after settling.
- `key_held` pulses high for 3 cycles only → no event.
- Hold 26 → `start_pulse` only; `guessed` unchanged. Hold 30 → no pulse.
- Assert `round_clear` in the EMIT cycle of a new letter 2 → `guess_valid` fires; afterwards `guessed`=0 and `guess_count`=0. Re-pressing 2 → `guess_valid` again.
